fifo_dac_reader: RTL and testbench
==================================

Name: fifo_dac_reader

Overview:
- Consumer end of the sample FIFO fed by the function generator.
- Pops one sample per sample period and serialises it MSB-first onto a 3-wire SPI-mode-0 DAC link (sclk/cs_n/mosi).
- Flags underrun when a sample slot arrives and the FIFO is empty.
- Sits between the FIFO read port and the DAC pins.

Parameters:
- DATA_WIDTH, 16, sample width; matches FIFO data width.
- SCLK_DIV, 2, sclk half-period in clk cycles (>=1).
- SAMPLE_PERIOD, 80, clk cycles between frame starts. Must be >= 2*SCLK_DIV*DATA_WIDTH+3.
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en_i  input  1  enable for the period counter and new frames.
- clr_underrun_i  input  1  synchronous clear of underrun_o.
- empty_i  input  1  FIFO empty flag.
- data_i  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_en_o.
- rd_en_o  output  1  FIFO pop, one-cycle pulse.
- sclk_o  output  1  DAC serial clock; idles low.
- cs_n_o  output  1  DAC chip select, active low.
- mosi_o  output  1  DAC serial data.
- busy_o  output  1  high when the FSM is not in R_IDLE.
- underrun_o  output  1  sticky underrun flag.
- frame_cnt_o  output  CNT_WIDTH  count of completed frames; wraps.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - rd_en_o=0, sclk_o=0, cs_n_o=1, mosi_o=0, busy_o=0, underrun_o=0, frame_cnt_o=0.
  - FSM to R_IDLE; period counter=0; shift register=0.
- Reset mid-frame aborts the frame immediately. No partial-frame completion.
- All outputs are registered.
- Period counter:
  - With en_i=1, counts 0..SAMPLE_PERIOD-1 and wraps.
  - tick is high in the cycle the count equals SAMPLE_PERIOD-1.
  - With en_i=0, the counter is held at 0 and no tick is generated.
- FSM states: R_IDLE, R_READ, R_LOAD, R_SHIFT, R_DONE.
- R_IDLE:
  - tick & !empty_i -> R_READ.
  - tick & empty_i -> set underrun_o, stay in R_IDLE.
- R_READ: rd_en_o=1 for exactly this cycle -> R_LOAD.
- R_LOAD:
  - Capture data_i into the shift register.
  - cs_n_o=0, mosi_o=data_i[DATA_WIDTH-1].
  - -> R_SHIFT.
- Cycle-level timing (tick at cycle T):
  - rd_en_o high in T+1.
  - cs_n_o low from T+2 (cycle L).
- R_SHIFT (sclk_gen produces an edge every SCLK_DIV cycles):
  - Rising edges at L+SCLK_DIV*(2i+1), falling edges at L+SCLK_DIV*(2i+2), for i=0..DATA_WIDTH-1.
  - On each falling edge except the last, shift left; mosi_o presents the next bit.
  - After the DATA_WIDTH-th falling edge -> R_DONE.
- R_DONE:
  - cs_n_o=1, mosi_o=0, frame_cnt_o+1 (wraps 2^CNT_WIDTH-1 -> 0).
  - -> R_IDLE.
- Frame shape: cs_n_o is low for exactly 2*SCLK_DIV*DATA_WIDTH cycles, and high for at least 1 cycle between frames.
- tick while not in R_IDLE (misconfigured SAMPLE_PERIOD): tick ignored, underrun_o set.
- en_i dropped mid-frame: the current frame completes normally, then no further frames.
- Simultaneous underrun set and clr_underrun_i: set wins (underrun_o=1).
- empty_i is sampled only in R_IDLE on tick. data_i is sampled only in R_LOAD.

Decomposition:
- fifo_defines_pkg gains:
  - typedef reader_state_t {R_IDLE, R_READ, R_LOAD, R_SHIFT, R_DONE}.
  - DAC defaults SCLK_DIV_DEF=2 and SAMPLE_PERIOD_DEF=80.
  - DATA_WIDTH is reused from the existing package.
- One sub-module, fifo_reader_sclk_gen:
  - Divides clk by SCLK_DIV while enabled.
  - Outputs sclk, rise_pulse, fall_pulse and a bit counter.
  - Asserts last_fall on the DATA_WIDTH-th falling edge.

Test Plan:
- Reset: assert rst=0 at L+10 of an active frame -> same-cycle cs_n_o=1, sclk_o=0, busy_o=0, frame_cnt_o unchanged from reset (0).
- Single sample 16'hA5C3, empty_i=0 until the pop then 1 -> rd_en_o high for 1 cycle; 16 rising sclk edges sample mosi=1010_0101_1100_0011; cs_n_o low 64 cycles; frame_cnt_o=1; underrun_o=0.
- Empty FIFO at tick -> no rd_en_o, cs_n_o stays 1, underrun_o=1; pulse clr_underrun_i -> 0 next cycle; clr coincident with a new empty tick -> underrun_o stays 1.
- Three queued samples 16'h0001, 16'h8000, 16'hFFFF -> cs_n_o falling edges exactly 80 cycles apart; bit streams match; frame_cnt_o=3.
- en_i dropped at L+20 -> frame completes in full (64 low cycles), no further rd_en_o for 300 cycles, busy_o=0 after R_DONE.
- CNT_WIDTH=2, 5 frames sent -> frame_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the sample FIFO and its DAC-side reader.
package fifo_defines_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int SCLK_DIV_DEF      = 2;
    localparam int SAMPLE_PERIOD_DEF = 80;

    typedef enum logic [2:0] {
        R_IDLE,
        R_READ,
        R_LOAD,
        R_SHIFT,
        R_DONE
    } reader_state_t;

endpackage

// File: rtl/fifo_reader_sclk_gen.sv
// Serial clock generator for the DAC link: toggles sclk every SCLK_DIV clk
// cycles while enabled and counts completed bits (falling edges).
// The pulse outputs are asserted in the cycle before the sclk register
// changes, so the reader can update mosi together with the falling edge.
module fifo_reader_sclk_gen #(
    parameter int  DATA_WIDTH = 16,
    parameter int  SCLK_DIV   = 2,
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic             o_sclk,
    output logic             o_rise_pulse,
    output logic             o_fall_pulse,
    output logic [BIT_W-1:0] o_bit_cnt,
    output logic             o_last_fall
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             w_toggle;

    assign w_toggle     = i_en && (r_div == DIV_W'(SCLK_DIV - 1));
    assign o_rise_pulse = w_toggle && !r_sclk;
    assign o_fall_pulse = w_toggle && r_sclk;
    assign o_last_fall  = o_fall_pulse && (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign o_sclk       = r_sclk;
    assign o_bit_cnt    = r_bit_cnt;

    // Divider, sclk register and bit counter; all cleared whenever disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
        end else if (!i_en) begin
            r_div     <= '0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
        end else if (w_toggle) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/fifo_dac_reader.sv
// Consumer end of the sample FIFO: pops one sample per sample period and
// shifts it MSB-first onto an SPI mode-0 DAC link.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   R_IDLE  | waiting for a period tick; empty FIFO on tick -> underrun
//   R_READ  | rd_en_o pulse to the FIFO
//   R_LOAD  | cs_n low, FIFO data captured into the shift register
//   R_SHIFT | sclk running, shift on every falling edge but the last
//   R_DONE  | cs_n high, frame counter incremented
module fifo_dac_reader
    import fifo_defines_pkg::*;
#(
    parameter int DATA_WIDTH    = fifo_defines_pkg::DATA_WIDTH,
    parameter int SCLK_DIV      = SCLK_DIV_DEF,
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_underrun_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rd_en_o,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    output logic                  busy_o,
    output logic                  underrun_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    reader_state_t         r_state;
    logic [PER_W-1:0]      r_period_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_rd_en;
    logic                  r_cs_n;
    logic                  r_busy;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;

    logic             w_tick;
    logic             w_gen_en;
    logic             w_sclk;
    logic             w_rise;
    logic             w_fall;
    logic             w_last_fall;
    logic [BIT_W-1:0] w_bit_cnt;
    logic             w_unused_gen;

    assign w_tick       = en_i && (r_period_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign w_gen_en     = (r_state == R_LOAD) || (r_state == R_SHIFT);
    assign w_unused_gen = &{1'b0, w_rise, w_bit_cnt};

    fifo_reader_sclk_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .SCLK_DIV   (SCLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_gen_en),
        .o_sclk       (w_sclk),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall),
        .o_bit_cnt    (w_bit_cnt),
        .o_last_fall  (w_last_fall)
    );

    // Sample-period counter; parked at zero while disabled so re-enabling
    // always gives a full period before the first tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period_cnt <= '0;
        end else if (!en_i || w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + PER_W'(1);
        end
    end

    // Reader FSM with all DAC-side outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= R_IDLE;
            r_shreg     <= '0;
            r_rd_en     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_rd_en <= 1'b0;

            // A tick we cannot serve (empty FIFO or frame still running)
            // is an underrun; setting beats a simultaneous clear.
            if (w_tick && ((r_state != R_IDLE) || empty_i)) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun_i) begin
                r_underrun <= 1'b0;
            end

            case (r_state)
                R_IDLE: begin
                    if (w_tick && !empty_i) begin
                        r_state <= R_READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                R_READ: begin
                    r_state <= R_LOAD;
                    r_cs_n  <= 1'b0;
                end
                R_LOAD: begin
                    r_shreg <= data_i;
                    r_state <= R_SHIFT;
                end
                R_SHIFT: begin
                    if (w_last_fall) begin
                        r_state <= R_DONE;
                        r_cs_n  <= 1'b1;
                        r_shreg <= '0;
                    end else if (w_fall) begin
                        r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                R_DONE: begin
                    r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                    r_state     <= R_IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= R_IDLE;
                    r_cs_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_shreg <= '0;
                end
            endcase
        end
    end

    assign rd_en_o     = r_rd_en;
    assign sclk_o      = w_sclk;
    assign cs_n_o      = r_cs_n;
    assign mosi_o      = r_shreg[DATA_WIDTH-1];
    assign busy_o      = r_busy;
    assign underrun_o  = r_underrun;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_fifo_dac_reader.sv
// Scoreboard bench for fifo_dac_reader: stimulus pushes samples into a FIFO
// model and the expected words into a queue; a monitor decodes each DAC
// frame and compares against the queue.
module tb_fifo_dac_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic        clr_underrun_i = 1'b0;
    logic        empty_i = 1'b1;
    logic [15:0] data_i = '0;

    logic        rd_en_o, sclk_o, cs_n_o, mosi_o, busy_o, underrun_o;
    logic [15:0] frame_cnt_o;
    logic        rd_en_2, sclk_2, cs_n_2, mosi_2, busy_2, underrun_2;
    logic [1:0]  frame_cnt_2;

    fifo_dac_reader #(.DATA_WIDTH(16), .SCLK_DIV(2), .SAMPLE_PERIOD(80), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .clr_underrun_i(clr_underrun_i),
        .empty_i(empty_i), .data_i(data_i), .rd_en_o(rd_en_o), .sclk_o(sclk_o),
        .cs_n_o(cs_n_o), .mosi_o(mosi_o), .busy_o(busy_o), .underrun_o(underrun_o),
        .frame_cnt_o(frame_cnt_o)
    );

    fifo_dac_reader #(.DATA_WIDTH(16), .SCLK_DIV(2), .SAMPLE_PERIOD(80), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en_i(en_i), .clr_underrun_i(clr_underrun_i),
        .empty_i(empty_i), .data_i(data_i), .rd_en_o(rd_en_2), .sclk_o(sclk_2),
        .cs_n_o(cs_n_2), .mosi_o(mosi_2), .busy_o(busy_2), .underrun_o(underrun_2),
        .frame_cnt_o(frame_cnt_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          fall_cyc[$];
    int          frames_done = 0;
    int          rd_pulses   = 0;
    int          cs_falls    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: pop on rd_en_o so data is valid the following cycle.
    always @(negedge clk) begin
        if (rd_en_o && (fifo_q.size() > 0)) data_i = fifo_q.pop_front();
        empty_i = (fifo_q.size() == 0);
    end

    // Monitor: decode frames on the DAC pins and score them.
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_rd = 1'b0;
    logic        in_frame = 1'b0, cnt_pend = 1'b0, rd_pend = 1'b0;
    int          low_len, nbits;
    logic [15:0] bits;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0; cnt_pend = 1'b0; rd_pend = 1'b0;
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_rd = 1'b0;
        end else begin
            if (cnt_pend) begin
                check("frame_cnt", frame_cnt_o, frames_done);
                check("frame_cnt_w2", frame_cnt_2, frames_done % 4);
                cnt_pend = 1'b0;
            end
            if (rd_pend) begin
                check("rd_en_width", rd_en_o, 0);
                rd_pend = 1'b0;
            end
            if (rd_en_o && !prev_rd) begin
                rd_pulses++;
                rd_pend = 1'b1;
            end
            if (!cs_n_o && prev_cs) begin
                in_frame = 1'b1; low_len = 0; nbits = 0; bits = '0;
                cs_falls++;
                fall_cyc.push_back(cyc);
            end
            if (in_frame && !cs_n_o) begin
                low_len++;
                if (sclk_o && !prev_sclk) begin
                    bits = {bits[14:0], mosi_o};
                    nbits++;
                end
            end
            if (in_frame && cs_n_o) begin
                in_frame = 1'b0;
                frames_done++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_data unexpected frame actual=%0h", bits);
                end else begin
                    check("frame_data", bits, exp_q.pop_front());
                end
                check("frame_bits", nbits, 16);
                check("cs_low_len", low_len, 64);
                cnt_pend = 1'b1;
            end
            prev_cs = cs_n_o; prev_sclk = sclk_o; prev_rd = rd_en_o;
        end
    end

    initial begin
        int t_u, l_cyc, rd0;
        logic [15:0] vecs [3];
        vecs[0] = 16'h0001; vecs[1] = 16'h8000; vecs[2] = 16'hFFFF;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en_o, 0);
        check("rst_sclk", sclk_o, 0);
        check("rst_cs_n", cs_n_o, 1);
        check("rst_mosi", mosi_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_underrun", underrun_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        rst = 1'b1;

        // Single sample.
        @(negedge clk);
        fifo_q.push_back(16'hA5C3); exp_q.push_back(16'hA5C3);
        en_i = 1'b1;
        for (int i = 0; i < 300 && frames_done < 1; i++) @(negedge clk);
        check("single_done", frames_done, 1);
        repeat (2) @(negedge clk);
        check("single_underrun", underrun_o, 0);
        check("single_rd_pulses", rd_pulses, 1);
        check("single_busy_after", busy_o, 0);

        // Empty FIFO at tick.
        for (int i = 0; i < 200 && !underrun_o; i++) @(negedge clk);
        t_u = cyc;
        check("empty_underrun_set", underrun_o, 1);
        check("empty_no_rd", rd_pulses, 1);
        check("empty_no_cs", cs_falls, 1);
        @(negedge clk); clr_underrun_i = 1'b1;
        @(negedge clk); clr_underrun_i = 1'b0;
        check("underrun_cleared", underrun_o, 0);
        while (cyc < t_u + 79) @(negedge clk);
        clr_underrun_i = 1'b1;
        @(negedge clk); clr_underrun_i = 1'b0;
        check("underrun_set_wins", underrun_o, 1);

        // Three queued samples.
        foreach (vecs[k]) begin
            fifo_q.push_back(vecs[k]);
            exp_q.push_back(vecs[k]);
        end
        for (int i = 0; i < 500 && frames_done < 4; i++) @(negedge clk);
        check("three_done", frames_done, 4);
        check("three_rd_pulses", rd_pulses, 4);
        if (fall_cyc.size() >= 4) begin
            check("frame_gap_1", fall_cyc[2] - fall_cyc[1], 80);
            check("frame_gap_2", fall_cyc[3] - fall_cyc[2], 80);
        end else begin
            check("frame_gap_count", fall_cyc.size(), 4);
        end

        // en_i dropped mid-frame.
        @(negedge clk);
        fifo_q.push_back(16'h3C96); exp_q.push_back(16'h3C96);
        for (int i = 0; i < 200 && cs_n_o; i++) @(negedge clk);
        check("endrop_started", cs_n_o, 0);
        l_cyc = cyc;
        while (cyc < l_cyc + 20) @(negedge clk);
        en_i = 1'b0;
        for (int i = 0; i < 100 && frames_done < 5; i++) @(negedge clk);
        check("endrop_done", frames_done, 5);
        rd0 = rd_pulses;
        fifo_q.push_back(16'h1234);
        repeat (300) @(negedge clk);
        check("endrop_no_rd", rd_pulses, rd0);
        check("endrop_no_cs", cs_falls, 5);
        check("endrop_busy", busy_o, 0);

        // Reset in the middle of a frame.
        en_i = 1'b1;
        for (int i = 0; i < 200 && cs_n_o; i++) @(negedge clk);
        check("rstmid_started", cs_n_o, 0);
        l_cyc = cyc;
        while (cyc < l_cyc + 10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_cs_n", cs_n_o, 1);
        check("rstmid_sclk", sclk_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_frame_cnt", frame_cnt_o, 0);
        check("rstmid_frame_cnt_w2", frame_cnt_2, 0);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
